// File: rtl/modular_addsub_pipe.sv
// Two-stage pipelined modular add/subtract (c = a +/- b mod q) with valid/ready and tag sideband.
// Optional input range flag on output range_err when RANGE_CHECK_EN is defined.
module modular_addsub_pipe #(
  parameter int unsigned    WIDTH      = 30,
  parameter int unsigned    Q_DEFAULT  = 12,
  parameter longint unsigned Q_OVERRIDE = 0,
  parameter int unsigned    TAG_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [3:0]       q_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
`ifdef RANGE_CHECK_EN
  output logic             range_err,
`endif
  output logic [TAG_W-1:0] out_tag
);

  function automatic logic [WIDTH-1:0] q_lookup(input logic [3:0] sel);
    logic [3:0]  idx;
    logic [29:0] q30;
    idx = (sel > 4'd12) ? 4'(Q_DEFAULT) : sel;
    case (idx)
      4'd0:    q30 = 30'd1063321601;
      4'd1:    q30 = 30'd1063452673;
      4'd2:    q30 = 30'd1064697857;
      4'd3:    q30 = 30'd1065484289;
      4'd4:    q30 = 30'd1065811969;
      4'd5:    q30 = 30'd1068236801;
      4'd6:    q30 = 30'd1068433409;
      4'd7:    q30 = 30'd1068564481;
      4'd8:    q30 = 30'd1069219841;
      4'd9:    q30 = 30'd1070727169;
      4'd10:   q30 = 30'd1071513601;
      4'd11:   q30 = 30'd1072496641;
      default: q30 = 30'd1073479681;
    endcase
    return WIDTH'(q30);
  endfunction

  logic             w_advance;
  logic [WIDTH-1:0] w_q_in;
  logic [WIDTH:0]   w_r;
  logic [WIDTH:0]   w_corr;
  logic [WIDTH-1:0] w_res;

  logic             r_s1_valid;
  logic             r_s1_sub;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [WIDTH-1:0] r_s1_q;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_c;
  logic [TAG_W-1:0] r_out_tag;

  // Whole pipeline moves in lockstep; a stalled output freezes both stages.
  assign w_advance = !r_s2_valid || out_ready;
  assign in_ready  = w_advance;

  always_comb begin
    w_q_in = q_lookup(q_sel);
    if (Q_OVERRIDE != 0) begin
      w_q_in = WIDTH'(Q_OVERRIDE);
    end
  end

  // r keeps one extra bit: carry for add, borrow (sign) for sub.
  always_comb begin
    w_r    = '0;
    w_corr = '0;
    if (r_s1_sub) begin
      w_r    = {1'b0, r_s1_a} - {1'b0, r_s1_b};
      w_corr = w_r[WIDTH] ? (w_r + {1'b0, r_s1_q}) : w_r;
    end else begin
      w_r    = {1'b0, r_s1_a} + {1'b0, r_s1_b};
      w_corr = (w_r >= {1'b0, r_s1_q}) ? (w_r - {1'b0, r_s1_q}) : w_r;
    end
    w_res = w_corr[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sub   <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_q     <= '0;
      r_s1_tag   <= '0;
      r_s2_valid <= 1'b0;
      r_c        <= '0;
      r_out_tag  <= '0;
    end else if (w_advance) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sub <= op_sub;
        r_s1_a   <= a;
        r_s1_b   <= b;
        r_s1_q   <= w_q_in;
        r_s1_tag <= in_tag;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_c       <= w_res;
        r_out_tag <= r_s1_tag;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign c         = r_c;
  assign out_tag   = r_out_tag;

`ifdef RANGE_CHECK_EN
  logic w_in_err;
  logic r_s1_err;
  logic r_s2_err;

  assign w_in_err = (a >= w_q_in) || (b >= w_q_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_err <= 1'b0;
      r_s2_err <= 1'b0;
    end else if (w_advance) begin
      if (in_valid) begin
        r_s1_err <= w_in_err;
      end
      if (r_s1_valid) begin
        r_s2_err <= r_s1_err;
      end
    end
  end

  assign range_err = r_s2_err;
`endif

endmodule

// File: tb/tb_modular_addsub_pipe.sv
// Self-checking bench for modular_addsub_pipe: directed vector table, stall/reset sequences and
// randomized traffic scored against a plain-arithmetic modular model.
module tb_modular_addsub_pipe;

  localparam int unsigned WIDTH = 30;
  localparam int unsigned TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [3:0]       q_sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic [TAG_W-1:0] out_tag;
`ifdef RANGE_CHECK_EN
  logic             range_err;
`endif

  modular_addsub_pipe #(
    .WIDTH(WIDTH),
    .Q_DEFAULT(12),
    .Q_OVERRIDE(0),
    .TAG_W(TAG_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op_sub(op_sub),
    .q_sel(q_sel),
    .a(a),
    .b(b),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .c(c),
`ifdef RANGE_CHECK_EN
    .range_err(range_err),
`endif
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  longint unsigned qtab [13] = '{
    1063321601, 1063452673, 1064697857, 1065484289, 1065811969, 1068236801,
    1068433409, 1068564481, 1069219841, 1070727169, 1071513601, 1072496641, 1073479681
  };

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint unsigned qof(input logic [3:0] sel);
    return (sel > 12) ? qtab[12] : qtab[sel];
  endfunction

  // Reference: true modular arithmetic on wide signed integers.
  function automatic longint model(input logic sub, input logic [3:0] sel,
                                   input longint x, input longint y);
    longint q;
    longint r;
    q = longint'(qof(sel));
    r = sub ? (x - y) : (x + y);
    r = r % q;
    if (r < 0) r = r + q;
    return r;
  endfunction

  typedef struct {
    longint     c;
    logic [7:0] tag;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  longint     cur_exp;
  logic       cur_err;
  logic [7:0] tag_ctr = 8'd1;

  always @(posedge clk) cyc++;

  // Scoreboard: sampled at negedge, handshakes complete on the following posedge.
  logic       prev_stall = 1'b0;
  longint     prev_c;
  logic [7:0] prev_tag;
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid", longint'(out_valid), 1);
        check("stall_hold_c", longint'(c), prev_c);
        check("stall_hold_tag", longint'(out_tag), longint'(prev_tag));
      end
      if (out_valid && !out_ready) check("stall_in_ready", longint'(in_ready), 0);
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got c=%0d tag=%0d with no beat outstanding", c, out_tag);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (c != WIDTH'(e.c) || out_tag != e.tag) begin
            errors++;
            $display("FAIL result: got c=%0d tag=%0d expected c=%0d tag=%0d", c, out_tag,
                     e.c, e.tag);
          end
`ifdef RANGE_CHECK_EN
          check("range_err", longint'(range_err), longint'(e.err));
`endif
        end
      end
      if (in_valid && in_ready) sb.push_back('{c: cur_exp, tag: in_tag, err: cur_err});
      prev_stall = out_valid && !out_ready;
      prev_c     = longint'(c);
      prev_tag   = out_tag;
    end
  end

  // Presents one beat (called at posedge+1) and returns at posedge+1 after it is accepted.
  task automatic send(input logic sub, input logic [3:0] sel, input longint x, input longint y,
                      input longint exp);
    logic acc;
    int   n;
    op_sub   = sub;
    q_sel    = sel;
    a        = WIDTH'(x);
    b        = WIDTH'(y);
    in_tag   = tag_ctr;
    tag_ctr  = tag_ctr + 8'd1;
    cur_exp  = exp;
    cur_err  = (x >= longint'(qof(sel))) || (y >= longint'(qof(sel)));
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected 1", n);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input int gap_max);
    logic       sub;
    logic [3:0] sel;
    longint     x;
    longint     y;
    sub = 1'($urandom);
    sel = 4'($urandom_range(15, 0));
    x   = longint'($urandom_range(32'(qof(sel) - 1), 0));
    y   = longint'($urandom_range(32'(qof(sel) - 1), 0));
    send(sub, sel, x, y, model(sub, sel, x, y));
    repeat ($urandom_range(gap_max, 0)) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", longint'(sb.size()), 0);
  endtask

  typedef struct {
    logic       sub;
    logic [3:0] sel;
    longint     x;
    longint     y;
    longint     exp;
  } vec_t;

  vec_t vecs[$];
  logic drv_done;

  initial begin
    int k;
    int c0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    op_sub    = 1'b0;
    q_sel     = 4'd0;
    a         = '0;
    b         = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    cur_exp   = 0;
    cur_err   = 1'b0;

    vecs.push_back('{1'b1, 4'd12, 1, 1073479680, 2});
    vecs.push_back('{1'b0, 4'd12, 1073479680, 1, 0});
    vecs.push_back('{1'b0, 4'd0, 0, 0, 0});
    vecs.push_back('{1'b1, 4'd12, 100, 23, 77});
    vecs.push_back('{1'b1, 4'd12, 9354, 1239384, 1072249651});
    vecs.push_back('{1'b0, 4'd3, 1065484288, 1065484288, 1065484287});
    vecs.push_back('{1'b1, 4'd7, 555, 555, 0});
    vecs.push_back('{1'b0, 4'd13, 1073479680, 1, 0});
    vecs.push_back('{1'b1, 4'd15, 1, 1073479680, 2});
    for (int i = 0; i < 13; i++) begin
      vecs.push_back('{1'b1, 4'(i), 1, longint'(qtab[i]) - 1, 2});
    end

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_c", longint'(c), 0);
    check("reset_out_tag", longint'(out_tag), 0);
    check("reset_in_ready", longint'(in_ready), 1);
`ifdef RANGE_CHECK_EN
    check("reset_range_err", longint'(range_err), 0);
`endif
    @(posedge clk);
    #1;

    // Latency: accept edge plus one more edge before out_valid.
    send(1'b1, 4'd12, 100, 23, 77);
    k = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      k++;
    end
    check("latency", k, 2);
    drain();
    @(posedge clk);
    #1;

    // Directed table, back-to-back, one accept per cycle.
    c0 = cyc;
    foreach (vecs[i]) send(vecs[i].sub, vecs[i].sel, vecs[i].x, vecs[i].y, vecs[i].exp);
    check("b2b_cycles", longint'(cyc - c0), longint'(vecs.size()));
    drain();
    @(posedge clk);
    #1;

    // 8-beat stream with a 3-cycle output stall in the middle.
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand(0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    @(posedge clk);
    #1;

    // Reset with two beats in flight: neither may emerge.
    send(1'b0, 4'd1, 10, 20, 30);
    send(1'b0, 4'd2, 40, 50, 90);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_flush_out_valid", longint'(out_valid), 0);
    check("rst_flush_in_ready", longint'(in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_flush_quiet", longint'(out_valid), 0);
    end
    @(posedge clk);
    #1;

`ifdef RANGE_CHECK_EN
    send(1'b0, 4'd12, 1073479681, 5, model(1'b0, 4'd12, 1073479681, 5));
    send(1'b1, 4'd12, 7, 3, 4);
    drain();
    @(posedge clk);
    #1;
`endif

    // Random traffic with random backpressure.
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) send_rand(2);
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(3, 0) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
